alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameters SHALL be: DATA_W, 8, operand/register width (fixed to match the ALU); REG_CNT, 8, register-file depth (3-bit indices).
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 Ports SHALL be (name direction width meaning):
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- instr_valid  in  1  instruction offered
- instr_ready  out  1  instruction accepted when valid&ready at edge
- instr_op  in  3  ALU opcode
- instr_rd  in  3  destination register
- instr_rs1  in  3  source register A
- instr_rs2  in  3  source register B
- ld_valid  in  1  direct register load offered
- ld_ready  out  1  load accepted when valid&ready at edge
- ld_addr  in  3  load target register
- ld_data  in  8  load value
- operand_a  out  8  to ALU operand A (registered)
- operand_b  out  8  to ALU operand B (registered)
- alu_opcode  out  3  to ALU opcode (registered)
- alu_result  in  8  combinational result from ALU
- done_valid  out  1  one-cycle completion pulse
- done_rd  out  3  destination of completed op
- done_data  out  8  value written back
- illegal  out  1  one-cycle pulse, rejected opcode
- busy  out  1  high when not IDLE
- dbg_addr  in  3  debug read index
- dbg_data  out  8  combinational read of reg[dbg_addr]

Function
REQ-004 Opcode map SHALL be: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT (operand A only); 110/111 illegal.
REQ-005 FSM SHALL have two states: IDLE and EXEC; busy = (state==EXEC).
REQ-006 ld_ready SHALL equal (state==IDLE); instr_ready SHALL equal (state==IDLE) & ~ld_valid (load has priority).
REQ-007 Load handshake SHALL write reg[ld_addr] <= ld_data at that edge; state stays IDLE; no done_valid.
REQ-008 Instruction handshake at edge E0 SHALL register operand_a <= reg[rs1], operand_b <= reg[rs2], alu_opcode <= instr_op, latch rd, and enter EXEC.
REQ-009 In EXEC, at edge E1, for legal opcode the block SHALL write reg[rd] <= alu_result, done_data <= alu_result, done_rd <= rd, done_valid <= 1, and return to IDLE.
REQ-010 For illegal opcode at E1 the block SHALL leave the register file unchanged, set illegal <= 1, keep done_valid 0, done_data/done_rd unchanged, and return to IDLE.
REQ-011 done_valid and illegal SHALL be high exactly one cycle (cycle after E1) and otherwise 0.
REQ-012 Latency SHALL be 2 cycles from handshake edge to done_valid; max throughput one instruction per 2 cycles (next accept no earlier than E2).
REQ-013 Register reads at E2 SHALL observe the E1 writeback (no hazard, no forwarding required); rd may equal rs1/rs2.
REQ-014 Arithmetic SHALL be modulo 2^8 (ALU wrap-around, no carry/borrow outputs); the block SHALL not alter alu_result.
REQ-015 operand_a/operand_b/alu_opcode SHALL hold their last values in IDLE.
REQ-016 All registers, including r0, SHALL be general-purpose (no hardwired zero).
REQ-017 instr_* and ld_* inputs SHALL be ignored when not accepted.

Reset
REQ-018 rst high at an edge SHALL set state IDLE, all 8 registers, operand_a, operand_b, alu_opcode, done_data, done_rd to 0, and done_valid, illegal to 0.
REQ-019 rst during EXEC SHALL abort the operation: no writeback, no done_valid, no illegal pulse.
REQ-020 rst SHALL override simultaneous load/instruction handshakes.

Verification
REQ-021 Load r1=0x0F, r2=0x01; ADD rd=3 rs1=1 rs2=2 -> done_valid 2 cycles after handshake, done_rd=3, done_data=0x10, dbg r3=0x10.
REQ-022 SUB rd=4 rs1=2 rs2=1 -> done_data=0xF2; r1=0xFF, r2=0x01 ADD -> 0x00 (wrap).
REQ-023 instr_op=110 with r5=0xAA, rd=5 -> illegal pulses 1 cycle, done_valid 0, r5 stays 0xAA.
REQ-024 ld_valid and instr_valid same IDLE cycle -> load taken, instr_ready=0; instruction accepted next cycle.
REQ-025 r1=0x0F, back-to-back ADD rd=1 rs1=1 rs2=1 twice -> done_data 0x1E then 0x3C, accepts 2 cycles apart.
REQ-026 rst asserted in EXEC -> no done_valid, all dbg reads 0, busy=0 next cycle.

Source files
------------

// File: rtl/alu_sequencer_if.sv
`default_nettype none
// ============================================================================
// alu_sequencer_if : instruction, load, ALU and debug signals of alu_sequencer
// Revision: 1.0
// ============================================================================
interface alu_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int IDX_W  = 3
);
    logic              instr_valid;
    logic              instr_ready;
    logic [2:0]        instr_op;
    logic [IDX_W-1:0]  instr_rd;
    logic [IDX_W-1:0]  instr_rs1;
    logic [IDX_W-1:0]  instr_rs2;
    logic              ld_valid;
    logic              ld_ready;
    logic [IDX_W-1:0]  ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic [DATA_W-1:0] operand_a;
    logic [DATA_W-1:0] operand_b;
    logic [2:0]        alu_opcode;
    logic [DATA_W-1:0] alu_result;
    logic              done_valid;
    logic [IDX_W-1:0]  done_rd;
    logic [DATA_W-1:0] done_data;
    logic              illegal;
    logic              busy;
    logic [IDX_W-1:0]  dbg_addr;
    logic [DATA_W-1:0] dbg_data;

    modport slave (
        input  instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2,
        input  ld_valid, ld_addr, ld_data, alu_result, dbg_addr,
        output instr_ready, ld_ready, operand_a, operand_b, alu_opcode,
        output done_valid, done_rd, done_data, illegal, busy, dbg_data
    );

    modport master (
        output instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2,
        output ld_valid, ld_addr, ld_data, alu_result, dbg_addr,
        input  instr_ready, ld_ready, operand_a, operand_b, alu_opcode,
        input  done_valid, done_rd, done_data, illegal, busy, dbg_data
    );
endinterface
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// alu_sequencer : two-state sequencer driving an external combinational ALU
//                 from an 8-entry register file, with direct load and debug read
// Revision: 1.0
// ============================================================================
module alu_sequencer #(
    parameter int DATA_W  = 8,
    parameter int REG_CNT = 8
) (
    input  wire logic      clk,
    input  wire logic      rst,
    alu_sequencer_if.slave bus
);
    localparam int IDX_W = $clog2(REG_CNT);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_EXEC = 1'b1;

    logic [0:0]        state_q;
    logic [0:0]        state_d;
    logic [DATA_W-1:0] regs_q [REG_CNT];
    logic [DATA_W-1:0] operand_a_q;
    logic [DATA_W-1:0] operand_b_q;
    logic [2:0]        alu_opcode_q;
    logic [IDX_W-1:0]  rd_q;
    logic [IDX_W-1:0]  done_rd_q;
    logic [DATA_W-1:0] done_data_q;
    logic              done_valid_q;
    logic              illegal_q;

    logic w_idle;
    logic w_ld_fire;
    logic w_instr_fire;
    logic w_op_legal;

    // A pending load blocks the instruction port for that cycle.
    always_comb begin
        w_idle       = (state_q == S_IDLE);
        w_ld_fire    = w_idle & bus.ld_valid;
        w_instr_fire = w_idle & bus.instr_valid & ~bus.ld_valid;
        w_op_legal   = (alu_opcode_q[2:1] != 2'b11);
        state_d      = state_q;
        if (w_instr_fire) begin
            state_d = S_EXEC;
        end else if (state_q == S_EXEC) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            operand_a_q  <= '0;
            operand_b_q  <= '0;
            alu_opcode_q <= '0;
            rd_q         <= '0;
            done_rd_q    <= '0;
            done_data_q  <= '0;
            done_valid_q <= 1'b0;
            illegal_q    <= 1'b0;
            for (int i = 0; i < REG_CNT; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            done_valid_q <= 1'b0;
            illegal_q    <= 1'b0;
            if (w_ld_fire) begin
                regs_q[bus.ld_addr] <= bus.ld_data;
            end else if (w_instr_fire) begin
                operand_a_q  <= regs_q[bus.instr_rs1];
                operand_b_q  <= regs_q[bus.instr_rs2];
                alu_opcode_q <= bus.instr_op;
                rd_q         <= bus.instr_rd;
            end
            // Writeback happens on the EXEC edge, so a read on the next accept sees it.
            if (state_q == S_EXEC) begin
                if (w_op_legal) begin
                    regs_q[rd_q] <= bus.alu_result;
                    done_data_q  <= bus.alu_result;
                    done_rd_q    <= rd_q;
                    done_valid_q <= 1'b1;
                end else begin
                    illegal_q <= 1'b1;
                end
            end
        end
    end

    assign bus.ld_ready    = w_idle;
    assign bus.instr_ready = w_idle & ~bus.ld_valid;
    assign bus.busy        = (state_q == S_EXEC);
    assign bus.operand_a   = operand_a_q;
    assign bus.operand_b   = operand_b_q;
    assign bus.alu_opcode  = alu_opcode_q;
    assign bus.done_valid  = done_valid_q;
    assign bus.done_rd     = done_rd_q;
    assign bus.done_data   = done_data_q;
    assign bus.illegal     = illegal_q;
    assign bus.dbg_data    = regs_q[bus.dbg_addr];
endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// tb_alu_sequencer : directed stimulus with a transaction-level reference model
// Revision: 1.0
// ============================================================================
module tb_alu_sequencer;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    bit   chk_en;

    alu_sequencer_if bus ();

    alu_sequencer #(.DATA_W(8), .REG_CNT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] alu_ref(input logic [2:0] op, input logic [7:0] a,
                                           input logic [7:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return ~a;
            default: return 8'h5A;
        endcase
    endfunction

    // External ALU: combinational on the sequencer's registered outputs.
    assign bus.alu_result = alu_ref(bus.alu_opcode, bus.operand_a, bus.operand_b);

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one pending transaction, results from plain arithmetic.
    logic [7:0] m_reg [8];
    bit         m_pend;
    logic [2:0] m_op, m_rd, m_done_rd;
    logic [7:0] m_a, m_b, m_done_data;
    bit         m_done, m_ill;

    always @(posedge clk) begin
        if (rst) begin
            foreach (m_reg[i]) m_reg[i] = 8'h00;
            m_pend = 0; m_op = 0; m_rd = 0; m_a = 0; m_b = 0;
            m_done_rd = 0; m_done_data = 0; m_done = 0; m_ill = 0;
        end else begin
            m_done = 0;
            m_ill  = 0;
            if (m_pend) begin
                m_pend = 0;
                if (m_op < 3'd6) begin
                    m_reg[m_rd] = alu_ref(m_op, m_a, m_b);
                    m_done_data = m_reg[m_rd];
                    m_done_rd   = m_rd;
                    m_done      = 1;
                end else begin
                    m_ill = 1;
                end
            end else if (bus.ld_valid) begin
                m_reg[bus.ld_addr] = bus.ld_data;
            end else if (bus.instr_valid) begin
                m_a    = m_reg[bus.instr_rs1];
                m_b    = m_reg[bus.instr_rs2];
                m_op   = bus.instr_op;
                m_rd   = bus.instr_rd;
                m_pend = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",        {7'd0, bus.busy},        {7'd0, m_pend});
            chk("ld_ready",    {7'd0, bus.ld_ready},    {7'd0, !m_pend});
            chk("instr_ready", {7'd0, bus.instr_ready}, {7'd0, !m_pend && !bus.ld_valid});
            chk("done_valid",  {7'd0, bus.done_valid},  {7'd0, m_done});
            chk("illegal",     {7'd0, bus.illegal},     {7'd0, m_ill});
            chk("done_rd",     {5'd0, bus.done_rd},     {5'd0, m_done_rd});
            chk("done_data",   bus.done_data,           m_done_data);
            chk("operand_a",   bus.operand_a,           m_a);
            chk("operand_b",   bus.operand_b,           m_b);
            chk("alu_opcode",  {5'd0, bus.alu_opcode},  {5'd0, m_op});
            chk("dbg_data",    bus.dbg_data,            m_reg[bus.dbg_addr]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [2:0] a, input logic [7:0] d);
        bus.ld_valid = 1'b1;
        bus.ld_addr  = a;
        bus.ld_data  = d;
        step();
        bus.ld_valid = 1'b0;
        bus.ld_data  = 8'($urandom);
    endtask

    task automatic set_instr(input logic [2:0] op, input logic [2:0] rd,
                             input logic [2:0] rs1, input logic [2:0] rs2);
        bus.instr_op  = op;
        bus.instr_rd  = rd;
        bus.instr_rs1 = rs1;
        bus.instr_rs2 = rs2;
    endtask

    task automatic dbg_chk(input logic [2:0] a, input logic [7:0] exp);
        bus.dbg_addr = a;
        #1;
        chk("dbg_lit", bus.dbg_data, exp);
    endtask

    // Issue one instruction from IDLE and check its literal outcome.
    task automatic run_op(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                          input logic [2:0] rs2, input logic [7:0] exp);
        set_instr(op, rd, rs1, rs2);
        bus.instr_valid = 1'b1;
        step();
        bus.instr_valid = 1'b0;
        chk("busy_lit", {7'd0, bus.busy}, 8'd1);
        chk("dv_early", {7'd0, bus.done_valid}, 8'd0);
        step();
        if (op < 3'd6) begin
            chk("dv_lit",   {7'd0, bus.done_valid}, 8'd1);
            chk("rd_lit",   {5'd0, bus.done_rd},    {5'd0, rd});
            chk("data_lit", bus.done_data,          exp);
        end else begin
            chk("ill_lit",    {7'd0, bus.illegal},    8'd1);
            chk("dv_ill_lit", {7'd0, bus.done_valid}, 8'd0);
        end
        step();
        chk("dv_pulse",  {7'd0, bus.done_valid}, 8'd0);
        chk("ill_pulse", {7'd0, bus.illegal},    8'd0);
    endtask

    initial begin
        n_vec = 0; n_err = 0; chk_en = 0;
        rst = 1'b1;
        bus.instr_valid = 0; bus.ld_valid = 0; bus.ld_addr = 0; bus.ld_data = 0;
        bus.dbg_addr = 0;
        set_instr(3'd0, 3'd0, 3'd0, 3'd0);
        step();
        chk_en = 1;
        step();
        rst = 1'b0;
        chk("rst_busy",  {7'd0, bus.busy},     8'd0);
        chk("rst_opa",   bus.operand_a,        8'd0);
        chk("rst_ready", {7'd0, bus.ld_ready}, 8'd1);

        load(3'd1, 8'h0F);
        load(3'd2, 8'h01);
        run_op(3'd0, 3'd3, 3'd1, 3'd2, 8'h10);
        dbg_chk(3'd3, 8'h10);
        run_op(3'd1, 3'd4, 3'd2, 3'd1, 8'hF2);
        dbg_chk(3'd4, 8'hF2);
        load(3'd1, 8'hFF);
        run_op(3'd0, 3'd6, 3'd1, 3'd2, 8'h00);
        run_op(3'd2, 3'd7, 3'd1, 3'd2, 8'h01);
        run_op(3'd3, 3'd7, 3'd1, 3'd2, 8'hFF);
        run_op(3'd4, 3'd0, 3'd1, 3'd2, 8'hFE);
        run_op(3'd5, 3'd2, 3'd2, 3'd0, 8'hFE);

        load(3'd5, 8'hAA);
        run_op(3'd6, 3'd5, 3'd1, 3'd2, 8'h00);
        dbg_chk(3'd5, 8'hAA);
        run_op(3'd7, 3'd5, 3'd5, 3'd5, 8'h00);
        dbg_chk(3'd5, 8'hAA);
        chk("data_hold", bus.done_data, 8'hFE);

        // Load and instruction offered together: load wins, instruction next cycle.
        bus.ld_valid = 1'b1; bus.ld_addr = 3'd2; bus.ld_data = 8'h33;
        set_instr(3'd0, 3'd3, 3'd2, 3'd2);
        bus.instr_valid = 1'b1;
        #1;
        chk("coll_ir", {7'd0, bus.instr_ready}, 8'd0);
        chk("coll_lr", {7'd0, bus.ld_ready},    8'd1);
        step();
        bus.ld_valid = 1'b0;
        chk("coll_idle", {7'd0, bus.busy}, 8'd0);
        #1;
        chk("coll_ir2", {7'd0, bus.instr_ready}, 8'd1);
        step();
        bus.instr_valid = 1'b0;
        chk("coll_busy", {7'd0, bus.busy}, 8'd1);
        step();
        chk("coll_dv",   {7'd0, bus.done_valid}, 8'd1);
        chk("coll_data", bus.done_data,          8'h66);
        step();

        // Back-to-back dependent ADDs with instr_valid held high.
        load(3'd1, 8'h0F);
        set_instr(3'd0, 3'd1, 3'd1, 3'd1);
        bus.instr_valid = 1'b1;
        step();
        chk("b2b_busy1", {7'd0, bus.busy}, 8'd1);
        step();
        chk("b2b_dv1",   {7'd0, bus.done_valid},  8'd1);
        chk("b2b_d1",    bus.done_data,           8'h1E);
        chk("b2b_rdy",   {7'd0, bus.instr_ready}, 8'd1);
        step();
        bus.instr_valid = 1'b0;
        chk("b2b_busy2", {7'd0, bus.busy},       8'd1);
        chk("b2b_dv0",   {7'd0, bus.done_valid}, 8'd0);
        step();
        chk("b2b_dv2",   {7'd0, bus.done_valid}, 8'd1);
        chk("b2b_d2",    bus.done_data,          8'h3C);
        step();

        // Reset in EXEC aborts the op and overrides a simultaneous load.
        set_instr(3'd0, 3'd1, 3'd1, 3'd1);
        bus.instr_valid = 1'b1;
        step();
        bus.instr_valid = 1'b0;
        rst = 1'b1;
        bus.ld_valid = 1'b1; bus.ld_addr = 3'd7; bus.ld_data = 8'h77;
        step();
        rst = 1'b0;
        bus.ld_valid = 1'b0;
        chk("rx_busy", {7'd0, bus.busy},       8'd0);
        chk("rx_dv",   {7'd0, bus.done_valid}, 8'd0);
        chk("rx_ill",  {7'd0, bus.illegal},    8'd0);
        step();
        chk("rx_dv2",  {7'd0, bus.done_valid}, 8'd0);
        for (int i = 0; i < 8; i++) dbg_chk(3'(i), 8'h00);

        load(3'd0, 8'h05);
        load(3'd7, 8'h03);
        run_op(3'd1, 3'd0, 3'd0, 3'd7, 8'h02);
        dbg_chk(3'd0, 8'h02);
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
